// File: rtl/ldw_fetch_unit.sv
// IF stage + IF/ID register: req/ack instruction fetch, 1-entry hold buffer, delay-slot redirects.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/bubble_cnt delivery counters.
module ldw_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] d_inst,
  output logic [31:0] d_pc4,
  output logic        d_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_tgt, r_hold_inst, r_hold_pc4;
  logic [31:0] r_d_inst, r_d_pc4;
  logic        r_tgt_valid, r_d_valid;

  logic        w_ack, w_redirect, w_direct, w_from_hold, w_deliver;
  logic [31:0] w_target, w_pc4;

  always_comb begin
    w_pc4       = r_pc + 32'd4;
    w_ack       = (r_state == S_FETCH) && imem_ack;
    w_redirect  = r_d_valid && nostall && (pcsource != 2'b00);
    w_from_hold = (r_state == S_HOLD) && nostall;
    w_direct    = w_ack && (!r_d_valid || nostall);
    w_deliver   = w_from_hold || w_direct;
    case (pcsource)
      2'b01:   w_target = bpc;
      2'b10:   w_target = rpc;
      default: w_target = jpc;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: if (w_ack && !w_direct) w_state_nxt = S_HOLD;
      S_HOLD:  if (nostall) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A redirect seen before the delay-slot word arrives is parked in r_tgt
  // so the outstanding request keeps a stable address until ack.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pc        <= RESET_PC;
      r_tgt       <= '0;
      r_tgt_valid <= 1'b0;
    end else if (w_ack) begin
      r_pc        <= w_redirect ? w_target : (r_tgt_valid ? r_tgt : w_pc4);
      r_tgt_valid <= 1'b0;
    end else if ((r_state == S_FETCH) && w_redirect) begin
      r_tgt       <= w_target;
      r_tgt_valid <= 1'b1;
    end else if ((r_state == S_HOLD) && w_redirect) begin
      r_pc        <= w_target;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_hold_inst <= '0;
      r_hold_pc4  <= '0;
    end else if (w_ack && !w_direct) begin
      r_hold_inst <= imem_rdata;
      r_hold_pc4  <= w_pc4;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_d_inst  <= '0;
      r_d_pc4   <= '0;
      r_d_valid <= 1'b0;
    end else if (w_from_hold) begin
      r_d_inst  <= r_hold_inst;
      r_d_pc4   <= r_hold_pc4;
      r_d_valid <= 1'b1;
    end else if (w_direct) begin
      r_d_inst  <= imem_rdata;
      r_d_pc4   <= w_pc4;
      r_d_valid <= 1'b1;
    end else if (nostall) begin
      r_d_inst  <= '0;
      r_d_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_bubble_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (w_deliver) begin
      r_fetch_cnt  <= r_fetch_cnt + 32'd1;
    end else if (nostall) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign d_inst    = r_d_inst;
  assign d_pc4     = r_d_pc4;
  assign d_valid   = r_d_valid;

endmodule

// File: tb/tb_ldw_fetch_unit.sv
// Bench for ldw_fetch_unit: queue-based fetch/delivery model checked every cycle plus directed literals.
module tb_ldw_fetch_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic [31:0] d_inst, d_pc4;
  logic        d_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  ldw_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .nostall    (nostall),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .d_inst     (d_inst),
    .d_pc4      (d_pc4),
    .d_valid    (d_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Memory: returns the address as the instruction word, acks after `lat` wait cycles.
  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  logic        ack_force = 1'b0;
  assign imem_ack   = ack_force | (imem_req & (wait_cnt >= lat));
  assign imem_rdata = imem_addr;
  always @(posedge clock) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: next fetch address, pending redirect keyed on the delay-slot address,
  // queue of fetched-but-undelivered words, and the expected IF/ID contents.
  bit          m_started, m_pend_v, m_dv, m_req, m_redir;
  logic [31:0] m_next, m_pend_from, m_pend_tgt, m_di, m_dp4, m_tgt, m_a;
  logic [31:0] m_q[$];
  logic [31:0] m_fcnt, m_bcnt;

  always @(negedge clock) begin
    if (!resetn) begin
      m_started = 0; m_pend_v = 0; m_dv = 0; m_di = '0; m_dp4 = '0;
      m_next = 32'h0000_0000; m_q.delete(); m_fcnt = '0; m_bcnt = '0;
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_dvalid", 32'(d_valid), 32'h0);
      chk("rst_dinst", d_inst, 32'h0);
      chk("rst_dpc4", d_pc4, 32'h0);
    end else begin
      m_req = m_started && (m_q.size() == 0);
      chk("req", 32'(imem_req), 32'(m_req));
      if (m_req) chk("addr", imem_addr, m_next);
      chk("dvalid", 32'(d_valid), 32'(m_dv));
      chk("dinst", d_inst, m_di);
      chk("dpc4", d_pc4, m_dp4);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, m_fcnt);
      chk("bubble_cnt", bubble_cnt, m_bcnt);
`endif
      m_redir = m_dv && nostall && (pcsource != 2'b00);
      m_tgt   = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? rpc : jpc;
      if (m_redir) begin
        if (m_q.size() != 0 && m_q[0] == m_dp4) m_next = m_tgt;
        else begin m_pend_v = 1; m_pend_from = m_dp4; m_pend_tgt = m_tgt; end
      end
      if (imem_ack && m_req) begin
        m_a = m_next;
        m_q.push_back(m_a);
        if (m_pend_v && m_pend_from == m_a) begin m_next = m_pend_tgt; m_pend_v = 0; end
        else m_next = m_a + 32'd4;
      end
      if (nostall || !m_dv) begin
        if (m_q.size() != 0) begin
          m_a = m_q.pop_front();
          m_di = m_a; m_dp4 = m_a + 32'd4; m_dv = 1; m_fcnt = m_fcnt + 32'd1;
        end else if (nostall) begin
          m_di = '0; m_dv = 0; m_bcnt = m_bcnt + 32'd1;
        end
      end
      m_started = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  initial begin
    resetn = 1'b0; nostall = 1'b1; pcsource = 2'b00;
    bpc = '0; rpc = '0; jpc = '0;
    step(3);
    resetn = 1'b1;
    chk("idle_req", 32'(imem_req), 32'h0);
    step(1);
    chk("first_req", 32'(imem_req), 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    step(1);
    chk("first_inst", d_inst, 32'h0);
    chk("first_pc4", d_pc4, 32'h4);
    chk("first_valid", 32'(d_valid), 32'h1);
    chk("addr4", imem_addr, 32'h4);
    step(2);
    chk("inst8", d_inst, 32'h8);
    nostall = 1'b0;
    step(1);
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_inst", d_inst, 32'h8);
    chk("hold_pc4", d_pc4, 32'hC);
    step(2);
    chk("hold_inst_late", d_inst, 32'h8);
    nostall = 1'b1;
    step(1);
    chk("resume_inst", d_inst, 32'hC);
    chk("resume_addr", imem_addr, 32'h10);
    step(1);
    chk("inst10", d_inst, 32'h10);
    pcsource = 2'b01; bpc = 32'h40;
    step(1);
    pcsource = 2'b00;
    chk("br_slot", d_inst, 32'h14);
    chk("br_addr", imem_addr, 32'h40);
    step(1);
    chk("br_tgt_inst", d_inst, 32'h40);
    nostall = 1'b0;
    step(1);
    chk("jr_hold_req", 32'(imem_req), 32'h0);
    nostall = 1'b1; pcsource = 2'b10; rpc = 32'h100;
    step(1);
    pcsource = 2'b00;
    chk("jr_slot", d_inst, 32'h44);
    chk("jr_addr", imem_addr, 32'h100);
    step(1);
    chk("jr_tgt_inst", d_inst, 32'h100);
    pcsource = 2'b11; jpc = 32'hFFFF_FFF8;
    step(1);
    pcsource = 2'b00;
    chk("j_addr", imem_addr, 32'hFFFF_FFF8);
    step(2);
    chk("wrap_inst", d_inst, 32'hFFFF_FFFC);
    chk("wrap_pc4", d_pc4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    step(2);

    resetn = 1'b0; lat = 3;
    step(2);
    resetn = 1'b1;
    for (int i = 0; i < 100 && !(d_valid && d_inst == 32'h10); i++) step(1);
    chk("lat_reach_10", d_inst, 32'h10);
    pcsource = 2'b11; jpc = 32'h200;
    step(1);
    pcsource = 2'b00;
    chk("lat_bubble", 32'(d_valid), 32'h0);
    chk("lat_wait1", imem_addr, 32'h14);
    step(1);
    chk("lat_wait2", imem_addr, 32'h14);
    step(1);
    chk("lat_wait3", imem_addr, 32'h14);
    chk("lat_wait3_req", 32'(imem_req), 32'h1);
    step(1);
    chk("lat_slot", d_inst, 32'h14);
    chk("lat_tgt", imem_addr, 32'h200);
    step(1);
    ack_force = 1'b1; resetn = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'h0);
    chk("async_valid", 32'(d_valid), 32'h0);
    step(2);
    ack_force = 1'b0; lat = 0; resetn = 1'b1;
    chk("rel_idle_req", 32'(imem_req), 32'h0);
    step(1);
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    step(1);
    chk("rel_inst", d_inst, 32'h0);
    chk("rel_pc4", d_pc4, 32'h4);
    chk("rel_valid", 32'(d_valid), 32'h1);
    step(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ldw_fetch_unit.md
Name: ldw_fetch_unit

Overview:
- Instruction-fetch (IF) stage and IF/ID pipeline register of the pipelined CPU; it produces the instruction word that the ID-stage control unit decodes.
- Fetches words from instruction memory over a req/ack handshake and presents instruction + PC+4 to ID.
- Honours ID's nostall (hold) and applies pcsource redirects (branch / jr / j / jal) with one architectural delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; word aligned.
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- nostall  in  1  from ID; 1 = ID consumes the IF/ID contents this cycle.
- pcsource  in  2  from ID: 00 sequential, 01 branch (bpc), 10 jr (rpc), 11 j/jal (jpc).
- bpc  in  32  branch target.
- rpc  in  32  jr target (forwarded rs value).
- jpc  in  32  jump target.
- d_inst  out  32  IF/ID instruction to ID.
- d_pc4  out  32  IF/ID PC+4 of d_inst.
- d_valid  out  1  d_inst is a real fetched instruction.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, state=IDLE, imem_req=0, d_inst=0, d_pc4=0, d_valid=0, hold buffer empty, tgt_valid=0.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: lasts exactly 1 cycle after reset release, then -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Both stay stable until imem_ack. Ack may arrive in the same cycle or any later cycle.
  - HOLD: imem_req=0. The fetched word sits in a 1-entry hold buffer because ID is stalled.
- Consume: consume = nostall. On consume, IF/ID takes the next available word: hold buffer, else the acked word this cycle, else a bubble (d_inst=0, d_valid=0, d_pc4 unchanged). When nostall=0, IF/ID holds all values.
- Ack in FETCH:
  - If IF/ID is empty (d_valid=0) or consume=1: the word goes straight to IF/ID (d_inst=imem_rdata, d_pc4=pc+4, d_valid=1); stay in FETCH.
  - Otherwise: the word goes to the hold buffer; -> HOLD.
  - Either way pc advances to the next fetch address (see Redirect).
- HOLD -> FETCH on consume. The held word moves to IF/ID that same cycle.
- Redirect event: d_valid & nostall & pcsource!=00. Target is selected from bpc/rpc/jpc by pcsource.
- Delay slot: the word at d_pc4 (outstanding or held) is always delivered. Only the address after it becomes the target.
- Next-address rule:
  - FETCH with ack: pc <= redirect ? target : tgt_valid ? tgt : pc+4. tgt_valid clears.
  - FETCH without ack plus redirect: tgt <= target, tgt_valid=1, pc unchanged.
  - HOLD plus redirect: pc <= target directly.
- Only the low 32 bits of pc+4 are kept; 32'hFFFF_FFFC wraps to 0.
- Nothing is ever dropped: no fetched word is discarded or duplicated. Throughput is 1 instruction/cycle with zero-wait memory and nostall=1.
- Reset mid-fetch aborts the outstanding request immediately (imem_req=0). An ack arriving while resetn=0 is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] (words delivered to IF/ID) and bubble_cnt[31:0] (consume cycles that delivered a bubble). Both counters are reset to 0 and wrap at 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Zero-wait memory, ack tied to req, nostall=1, rdata=addr: imem_addr 0x0,0x4,0x8,... on consecutive cycles; d_inst=0x0 with d_pc4=0x4 one cycle after the first ack, then contiguous.
- nostall=0 for 3 cycles after d_inst=0x8: d_inst, d_pc4 and d_valid are held; the word at 0xC is held; imem_req=0 in HOLD; on nostall=1, d_inst=0xC then 0x10.
- beq in IF/ID at 0x10, pcsource=01, bpc=0x40: fetch order 0x10, 0x14, 0x40; delay slot word 0x14 reaches d_inst before 0x40.
- 3-cycle ack latency with redirect jpc=0x200 during the wait on 0x14: imem_addr stays 0x14 until ack, next request 0x200.
- Redirect in HOLD, jr with rpc=0x100: pc becomes 0x100; the held delay slot is delivered first, then 0x100 is fetched.
- resetn low while a request is outstanding: imem_req and d_valid go low asynchronously; after release, 1 IDLE cycle, then a fetch of RESET_PC.
